dt_traverse_engine: RTL and testbench
=====================================

# dt_traverse_engine

Parametrised decision-tree traversal engine for the BDD accelerator. It accepts one feature vector per transaction, walks a node table held in an internal synchronous RAM from the root down to a leaf, and returns the leaf's class label with path depth and an error flag. It generalises the fixed 5×8-bit single-tree datapath to configurable feature count and width, node-table depth and class width, and adds valid/ready handshakes, a host load port and fault detection.

## Interface
- FEAT_W, 8: feature and threshold width (unsigned)
- NUM_FEAT, 5: features per vector
- NODE_AW, 6: node-table address width; depth 2**NODE_AW
- CLASS_W, 4: class label width
- MAX_DEPTH, 16: node-visit limit (see Configuration)
- Derived: FIDX_W = max(1, $clog2(NUM_FEAT)); DEPTH_W = $clog2(MAX_DEPTH+1); NODE_W = 1 + FIDX_W + FEAT_W + 2*NODE_AW
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine idle, vector accepted on in_valid & in_ready
- in_feat  in  NUM_FEAT*FEAT_W  features, feature i at [i*FEAT_W +: FEAT_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  CLASS_W  leaf class
- out_depth  out  DEPTH_W  nodes visited including the leaf
- out_err  out  1  traversal fault
- cfg_we  in  1  node-table write strobe
- cfg_addr  in  NODE_AW  node address
- cfg_wdata  in  NODE_W  node word

## Operation
- Node word, MSB down: leaf flag; feature index; threshold; left child; right child. For a leaf, class = bits [CLASS_W-1:0]; the other fields are ignored.
- Root is address 0.
- Internal node: feature[idx] < threshold (unsigned) → left child, else right child. Equal goes right.
- FSM states: IDLE, FETCH, EVAL, DONE.
  - IDLE: in_ready=1. On accept, latch in_feat, addr←0, depth←0, go FETCH.
  - FETCH: present addr to RAM, go EVAL.
  - EVAL: RAM data valid; depth+1.
    - Leaf → class, DONE.
    - Feature index ≥ NUM_FEAT → err=1, class=0, DONE.
    - Otherwise addr←selected child, go FETCH.
  - DONE: out_valid=1. On out_ready, go IDLE.
- cfg writes take effect only in IDLE; in other states they are dropped.
- Simultaneous cfg_we and accept in IDLE: the write completes at that edge, and the traversal reads the updated word.
- Outputs hold stable while out_valid=1 and out_ready=0.
- RAM contents are not reset.

## Timing
- Reset values: in_ready=1, out_valid=0, out_class=0, out_depth=0, out_err=0; state IDLE.
- Reset asserted mid-traversal aborts it immediately. The latched vector is discarded.
- RAM read latency is 1 cycle. Each node costs 2 cycles (FETCH, EVAL).
- Accept at edge T → out_valid high from edge T+2N+1, where N = nodes visited.
- in_ready is low from the accept edge until the cycle after the out_valid & out_ready handshake.
- There is no overlap between transactions: throughput is one vector per 2N+2 cycles with out_ready held high.

## Configuration
- DT_TRAVERSE_DEPTH_LIMIT_EN defined:
  - An EVAL at an internal node with depth+1 == MAX_DEPTH terminates with err=1, class=0, out_depth=MAX_DEPTH.
  - This guarantees termination on cyclic tables.
- Undefined:
  - No limit; a cyclic table hangs until reset.
  - out_depth saturates at 2**DEPTH_W-1.

## Structure
- Package dt_pkg holds:
  - FSM state enum
  - node-field offset/width functions of the parameters
  - leaf-flag position constant
- One sub-module, dt_node_ram: single-port, synchronous-read, write-first RAM of 2**NODE_AW × NODE_W, no reset.

## Test plan
- Root leaf class 3 → out_class=3, out_depth=1, out_err=0, out_valid 3 cycles after accept.
- Tree: root idx 2, thr 100, left leaf class 1, right leaf class 2. Stimulus feat[2]=99 → class 1; feat[2]=100 → class 2; depth 2 in both cases, latency 5.
- Hold out_ready low 5 cycles at DONE → outputs stable, in_ready=0. Then out_ready=1 → in_ready=1 the next cycle, and a back-to-back vector is accepted.
- With macro, MAX_DEPTH=16, node 0 left child 0, feature < thr → out_err=1, out_class=0, out_depth=16.
- NUM_FEAT=5, root idx 7 → out_err=1, out_class=0, out_depth=1.
- cfg write to node 0 during EVAL is ignored (next result unchanged). rst_n low in FETCH → out_valid=0, in_ready=1 asynchronously; a fresh vector is then processed correctly.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared types and node-word layout helpers for the decision-tree traversal engine.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state enum, width/offset functions of the engine parameters, field positions.
package dt_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EVAL  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Feature-index field is never narrower than one bit, even for a single feature.
   function automatic int fidx_w(input int num_feat);
      return (num_feat > 1) ? $clog2(num_feat) : 1;
   endfunction

   function automatic int depth_w(input int max_depth);
      return $clog2(max_depth + 1);
   endfunction

   function automatic int node_w(input int feat_w, input int num_feat, input int node_aw);
      return 1 + fidx_w(num_feat) + feat_w + 2 * node_aw;
   endfunction

   // Node word packed from the LSB: right child, left child, threshold, feature index, leaf flag.
   localparam int RIGHT_LSB = 0;

   function automatic int left_lsb(input int node_aw);
      return node_aw;
   endfunction

   function automatic int thr_lsb(input int node_aw);
      return 2 * node_aw;
   endfunction

   function automatic int fidx_lsb(input int feat_w, input int node_aw);
      return 2 * node_aw + feat_w;
   endfunction

   // Leaf flag is always the MSB of the node word.
   function automatic int leaf_pos(input int feat_w, input int num_feat, input int node_aw);
      return node_w(feat_w, num_feat, node_aw) - 1;
   endfunction

endpackage

// File: rtl/dt_traverse_engine_if.sv
// Handshake bundle for the traversal engine: feature input, result output, node-table load port.
// Latency: n/a (wires only). Backpressure: in_ready/out_ready valid-ready pairs.
// Modports: slave = engine side, master = host/testbench side.
interface dt_traverse_engine_if
   import dt_pkg::*;
#(
   parameter int FEAT_W    = 8,
   parameter int NUM_FEAT  = 5,
   parameter int NODE_AW   = 6,
   parameter int CLASS_W   = 4,
   parameter int MAX_DEPTH = 16
) ();
   localparam int DEPTH_W = depth_w(MAX_DEPTH);
   localparam int NODE_W  = node_w(FEAT_W, NUM_FEAT, NODE_AW);

   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_FEAT*FEAT_W-1:0]   in_feat;
   logic                         out_valid;
   logic                         out_ready;
   logic [CLASS_W-1:0]           out_class;
   logic [DEPTH_W-1:0]           out_depth;
   logic                         out_err;
   logic                         cfg_we;
   logic [NODE_AW-1:0]           cfg_addr;
   logic [NODE_W-1:0]            cfg_wdata;

   modport slave (
      input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
      output in_ready, out_valid, out_class, out_depth, out_err
   );

   modport master (
      output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
      input  in_ready, out_valid, out_class, out_depth, out_err
   );
endinterface

// File: rtl/dt_node_ram.sv
// Node table: single-port, synchronous-read, write-first RAM, no reset on contents.
// Latency: 1 cycle read. Backpressure: none (caller arbitrates the single port).
// Ports: i_clk, i_we, i_addr, i_wdata, o_rdata (write data is forwarded to o_rdata on a write).
module dt_node_ram #(
   parameter int AW = 6,
   parameter int DW = 24
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [2**AW];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
         o_rdata       <= i_wdata;
      end else begin
         o_rdata <= r_mem[i_addr];
      end
   end
endmodule

// File: rtl/dt_traverse_engine.sv
// Decision-tree traversal: walks the node table from root 0 to a leaf, returns class/depth/err.
// Latency: 2 cycles per visited node, out_valid from edge T+2N+1 after accept edge T.
// Backpressure: one transaction in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk, rst_n (async active-low), bus (dt_traverse_engine_if.slave).
// Optional macro DT_TRAVERSE_DEPTH_LIMIT_EN: abort with err once MAX_DEPTH nodes are visited.
module dt_traverse_engine
   import dt_pkg::*;
#(
   parameter int FEAT_W    = 8,
   parameter int NUM_FEAT  = 5,
   parameter int NODE_AW   = 6,
   parameter int CLASS_W   = 4,
   parameter int MAX_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dt_traverse_engine_if.slave  bus
);
   localparam int FIDX_W   = fidx_w(NUM_FEAT);
   localparam int DEPTH_W  = depth_w(MAX_DEPTH);
   localparam int NODE_W   = node_w(FEAT_W, NUM_FEAT, NODE_AW);
   localparam int LEAF_POS = leaf_pos(FEAT_W, NUM_FEAT, NODE_AW);
   localparam int FIDX_LSB = fidx_lsb(FEAT_W, NODE_AW);
   localparam int THR_LSB  = thr_lsb(NODE_AW);
   localparam int LEFT_LSB = left_lsb(NODE_AW);

   state_e                      r_state, w_state_nxt;
   logic [NUM_FEAT*FEAT_W-1:0]  r_feat;
   logic [NODE_AW-1:0]          r_addr;
   logic [DEPTH_W-1:0]          r_depth;
   logic [CLASS_W-1:0]          r_class;
   logic                        r_err;

   logic                        w_accept, w_ram_we;
   logic [NODE_AW-1:0]          w_ram_addr;
   logic [NODE_W-1:0]           w_rdata;
   logic                        w_leaf, w_bad_idx, w_limit, w_fault, w_stop;
   logic [FIDX_W-1:0]           w_fidx;
   logic [FEAT_W-1:0]           w_thr, w_fval;
   logic [NODE_AW-1:0]          w_left, w_right;
   logic [DEPTH_W-1:0]          w_depth_inc;

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.out_class = r_class;
   assign bus.out_depth = r_depth;
   assign bus.out_err   = r_err;

   assign w_accept = bus.in_valid && (r_state == S_IDLE);

   // The single RAM port belongs to the host in IDLE and to the walker otherwise,
   // so host writes outside IDLE are simply dropped.
   assign w_ram_we   = bus.cfg_we && (r_state == S_IDLE);
   assign w_ram_addr = (r_state == S_IDLE) ? bus.cfg_addr : r_addr;

   dt_node_ram #(.AW(NODE_AW), .DW(NODE_W)) u_ram (
      .i_clk   (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (bus.cfg_wdata),
      .o_rdata (w_rdata)
   );

   assign w_leaf  = w_rdata[LEAF_POS];
   assign w_fidx  = w_rdata[FIDX_LSB +: FIDX_W];
   assign w_thr   = w_rdata[THR_LSB +: FEAT_W];
   assign w_left  = w_rdata[LEFT_LSB +: NODE_AW];
   assign w_right = w_rdata[RIGHT_LSB +: NODE_AW];

   assign w_bad_idx   = 32'(w_fidx) >= 32'(NUM_FEAT);
   assign w_depth_inc = (r_depth == '1) ? r_depth : r_depth + 1'b1;

`ifdef DT_TRAVERSE_DEPTH_LIMIT_EN
   assign w_limit = (w_depth_inc == DEPTH_W'(MAX_DEPTH));
`else
   assign w_limit = 1'b0;
`endif

   // Faults only apply to internal nodes; a leaf always terminates cleanly.
   assign w_fault = !w_leaf && (w_bad_idx || w_limit);
   assign w_stop  = w_leaf || w_fault;

   // Only in-range indices can match, so an out-of-range index leaves w_fval at zero.
   always_comb begin
      w_fval = '0;
      for (int i = 0; i < NUM_FEAT; i++) begin
         if (w_fidx == FIDX_W'(i)) w_fval = r_feat[i*FEAT_W +: FEAT_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_EVAL;
         S_EVAL:  w_state_nxt = w_stop ? S_DONE : S_FETCH;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_feat  <= '0;
         r_addr  <= '0;
         r_depth <= '0;
         r_class <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_feat  <= bus.in_feat;
            r_addr  <= '0;
            r_depth <= '0;
            r_class <= '0;
            r_err   <= 1'b0;
         end else if (r_state == S_EVAL) begin
            r_depth <= w_depth_inc;
            if (w_leaf) begin
               r_class <= w_rdata[CLASS_W-1:0];
            end else if (w_fault) begin
               r_class <= '0;
               r_err   <= 1'b1;
            end else begin
               // Strictly-less goes left; equal goes right.
               r_addr <= (w_fval < w_thr) ? w_left : w_right;
            end
         end
      end
   end
endmodule

// File: tb/tb_dt_traverse_engine.sv
// Scoreboard bench for dt_traverse_engine: directed vectors, expected results queued at accept,
// a negedge monitor compares class/depth/err/latency whenever out_valid is presented.
module tb_dt_traverse_engine;
   import dt_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dt_traverse_engine_if #(.FEAT_W(8), .NUM_FEAT(5), .NODE_AW(6), .CLASS_W(4), .MAX_DEPTH(16)) bus ();

   dt_traverse_engine #(.FEAT_W(8), .NUM_FEAT(5), .NODE_AW(6), .CLASS_W(4), .MAX_DEPTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] cls;
      int         dep;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];
   logic prev_vld = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Node words: [23] leaf, [22:20] fidx, [19:12] thr, [11:6] left, [5:0] right.
   function automatic logic [23:0] nint(input logic [2:0] fi, input logic [7:0] thr,
                                        input logic [5:0] l, input logic [5:0] r);
      return {1'b0, fi, thr, l, r};
   endfunction

   function automatic logic [23:0] nleaf(input logic [3:0] c);
      return {1'b1, 19'd0, c};
   endfunction

   function automatic logic [39:0] mkf(input logic [7:0] f0, input logic [7:0] f1,
                                       input logic [7:0] f2, input logic [7:0] f3,
                                       input logic [7:0] f4);
      return {f4, f3, f2, f1, f0};
   endfunction

   task automatic cfg(input logic [5:0] a, input logic [23:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      @(posedge clk); #1;
      bus.cfg_we    = 1'b0;
   endtask

   task automatic push_exp(input logic [3:0] c, input int dep, input logic e, input int nodes);
      exp_t x;
      x.cls = c; x.dep = dep; x.err = e; x.lat = 2 * nodes + 1; x.acc = cyc;
      sb.push_back(x);
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!bus.in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_rdy_wait", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic send(input logic [39:0] f, input logic [3:0] c, input int dep,
                       input logic e, input int nodes);
      wait_rdy();
      bus.in_valid = 1'b1;
      bus.in_feat  = f;
      @(posedge clk); #1;
      push_exp(c, dep, e, nodes);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compares every cycle the result is presented (so held outputs are checked
   // for stability under backpressure) and pops on the handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_vld = 1'b0;
      end else begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("unexp_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               if (!prev_vld) chk("latency", 32'(cyc + 1 - sb[0].acc), 32'(sb[0].lat));
               chk("out_class", 32'(bus.out_class), 32'(sb[0].cls));
               chk("out_depth", 32'(bus.out_depth), 32'(sb[0].dep));
               chk("out_err",   32'(bus.out_err),   32'(sb[0].err));
               chk("in_rdy_busy", 32'(bus.in_ready), 32'd0);
               if (bus.out_ready) void'(sb.pop_front());
            end
         end
         prev_vld = bus.out_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_feat   = '0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;

      #1 rst_n = 1'b0;
      #2;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_class", 32'(bus.out_class), 32'd0);
      chk("rst_out_depth", 32'(bus.out_depth), 32'd0);
      chk("rst_out_err",   32'(bus.out_err),   32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Root leaf.
      cfg(6'd0, nleaf(4'd3));
      send(mkf(0, 0, 0, 0, 0), 4'd3, 1, 1'b0, 1);
      drain();

      // Two-level tree on feature 2, threshold 100; equal goes right.
      cfg(6'd0, nint(3'd2, 8'd100, 6'd1, 6'd2));
      cfg(6'd1, nleaf(4'd1));
      cfg(6'd2, nleaf(4'd2));
      send(mkf(0, 0, 99, 0, 0),  4'd1, 2, 1'b0, 2);
      send(mkf(0, 0, 100, 0, 0), 4'd2, 2, 1'b0, 2);
      drain();

      // Backpressure: result held 5 cycles, then back-to-back accept after handshake.
      bus.out_ready = 1'b0;
      send(mkf(255, 255, 0, 255, 255), 4'd1, 2, 1'b0, 2);
      begin
         int n = 0;
         while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("bp_valid_seen", 32'(bus.out_valid), 32'd1);
      repeat (5) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rdy_after_hs", 32'(bus.in_ready), 32'd1);
      send(mkf(0, 0, 200, 0, 0), 4'd2, 2, 1'b0, 2);
      drain();

      // Highest feature index selects feature 4.
      cfg(6'd0, nint(3'd4, 8'd50, 6'd1, 6'd2));
      send(mkf(0, 0, 0, 0, 49),  4'd1, 2, 1'b0, 2);
      send(mkf(99, 99, 99, 99, 50), 4'd2, 2, 1'b0, 2);
      drain();

      // Feature index out of range at the root.
      cfg(6'd0, nint(3'd7, 8'd0, 6'd1, 6'd2));
      send(mkf(0, 0, 0, 0, 0), 4'd0, 1, 1'b1, 1);
      cfg(6'd0, nint(3'd5, 8'd0, 6'd1, 6'd2));
      send(mkf(0, 0, 0, 0, 0), 4'd0, 1, 1'b1, 1);
      drain();

      // cfg write during EVAL is dropped.
      cfg(6'd0, nint(3'd2, 8'd100, 6'd1, 6'd2));
      send(mkf(0, 0, 99, 0, 0), 4'd1, 2, 1'b0, 2);
      @(posedge clk); #1;
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 6'd0;
      bus.cfg_wdata = nleaf(4'd7);
      @(posedge clk); #1;
      bus.cfg_we    = 1'b0;
      drain();
      send(mkf(0, 0, 99, 0, 0), 4'd1, 2, 1'b0, 2);
      drain();

      // cfg write coincident with accept: traversal sees the new root.
      wait_rdy();
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 6'd0;
      bus.cfg_wdata = nleaf(4'd5);
      bus.in_valid  = 1'b1;
      bus.in_feat   = mkf(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      push_exp(4'd5, 1, 1'b0, 1);
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      drain();

      // Reset during FETCH aborts asynchronously; RAM contents survive.
      cfg(6'd0, nint(3'd2, 8'd100, 6'd1, 6'd2));
      wait_rdy();
      bus.in_valid = 1'b1;
      bus.in_feat  = mkf(0, 0, 10, 0, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("busy_before_rst", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
      chk("abort_out_depth", 32'(bus.out_depth), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(mkf(0, 0, 100, 0, 0), 4'd2, 2, 1'b0, 2);
      drain();

      // 32 internal nodes chained via right child (thr 0), leaf at node 32.
      for (int i = 0; i < 32; i++) cfg(6'(i), nint(3'd0, 8'd0, 6'd63, 6'(i + 1)));
      cfg(6'd32, nleaf(4'd9));
`ifdef DT_TRAVERSE_DEPTH_LIMIT_EN
      send(mkf(0, 0, 0, 0, 0), 4'd0, 16, 1'b1, 16);
      drain();
      // Self-loop at the root must terminate at the depth limit.
      cfg(6'd0, nint(3'd0, 8'd10, 6'd0, 6'd0));
      send(mkf(5, 0, 0, 0, 0), 4'd0, 16, 1'b1, 16);
      drain();
`else
      // 33 nodes visited; depth saturates at 31.
      send(mkf(0, 0, 0, 0, 0), 4'd9, 31, 1'b0, 33);
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
